// File: rtl/ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : ctrl_unit_pkg
// Brief  : Shared opcodes, dst codes, bus selects, state encoding, control word
// Rev    : 1.0
// ============================================================================
package ctrl_unit_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam logic [1:0] DST_R1 = 2'b00;
    localparam logic [1:0] DST_R2 = 2'b01;
    localparam logic [1:0] DST_R3 = 2'b10;
    localparam logic [1:0] DST_AR = 2'b11;

    localparam int         SEL_W    = 3;
    localparam logic [2:0] SEL_X    = 3'd0;
    localparam logic [2:0] SEL_R1   = 3'd1;
    localparam logic [2:0] SEL_R2   = 3'd2;
    localparam logic [2:0] SEL_MEM  = 3'd3;
    localparam logic [2:0] SEL_R3   = 3'd4;
    localparam logic [2:0] SEL_NULL = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_ADDR = 3'd2,
        ST_MEM  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // ld[0..3] drive l1..l4
    typedef struct packed {
        logic             ready;
        logic             done;
        logic [3:0]       ld;
        logic [SEL_W-1:0] s1;
        logic [SEL_W-1:0] s2;
        logic             f;
        logic             w;
        logic             r;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{ready: 1'b1, done: 1'b0, ld: 4'b0000,
                                    s1: SEL_NULL, s2: SEL_NULL,
                                    f: 1'b0, w: 1'b0, r: 1'b0};

    function automatic logic [3:0] dst_onehot(input logic [1:0] dst);
        logic [3:0] oh;
        oh      = 4'b0000;
        oh[dst] = 1'b1;
        return oh;
    endfunction

endpackage : ctrl_unit_pkg
`default_nettype wire

// File: rtl/ctrl_unit_src_sel_dec.sv
`default_nettype none
// ============================================================================
// Module : src_sel_dec
// Brief  : Maps a 2-bit instruction source code onto a bus-select code
// Rev    : 1.0
// ============================================================================
module src_sel_dec
    import ctrl_unit_pkg::*;
(
    input  logic [1:0]       code_i,
    output logic [SEL_W-1:0] sel_o
);

    always_comb begin
        sel_o = SEL_X;
        case (code_i)
            2'b00:   sel_o = SEL_X;
            2'b01:   sel_o = SEL_R1;
            2'b10:   sel_o = SEL_R2;
            default: sel_o = SEL_R3;
        endcase
    end

endmodule : src_sel_dec
`default_nettype wire

// File: rtl/ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module : ctrl_unit
// Brief  : Multi-cycle datapath controller for ADD/SUB/LOAD/STORE, registered outputs
// Rev    : 1.0
// ============================================================================
module ctrl_unit
    import ctrl_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       instr,
    output logic             ready,
    output logic             done,
    output logic             l1,
    output logic             l2,
    output logic             l3,
    output logic             l4,
    output logic [SEL_W-1:0] s1,
    output logic [SEL_W-1:0] s2,
    output logic             f,
    output logic             w,
    output logic             r
);

    state_t           state_q, state_d;
    logic [7:0]       instr_q, instr_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic [1:0]       op_d, dst_d;

    assign op_d  = instr_d[7:6];
    assign dst_d = instr_d[5:4];

    src_sel_dec u_dec_a (.code_i(instr_d[3:2]), .sel_o(sel_a));
    src_sel_dec u_dec_b (.code_i(instr_d[1:0]), .sel_o(sel_b));

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    instr_d = instr;
                    state_d = instr[7] ? ST_ADDR : ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_DONE;
            ST_ADDR: state_d = ST_MEM;
            ST_MEM:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Controls are decoded for the state being entered so they can be
    // registered and still line up with that state.
    always_comb begin
        ctrl_d = CTRL_IDLE;
        if (state_d != ST_IDLE) begin
            ctrl_d.ready = 1'b0;
        end
        case (state_d)
            ST_EXEC: begin
                ctrl_d.s1 = sel_a;
                ctrl_d.s2 = sel_b;
                ctrl_d.f  = op_d[0];
                ctrl_d.ld = dst_onehot(dst_d);
            end
            ST_ADDR: begin
                ctrl_d.s1 = sel_a;
                ctrl_d.ld = dst_onehot(DST_AR);
            end
            ST_MEM: begin
                if (op_d == OP_LOAD) begin
                    ctrl_d.r  = 1'b1;
                    ctrl_d.s1 = SEL_MEM;
                    ctrl_d.ld = dst_onehot(dst_d);
                end else begin
                    ctrl_d.w  = 1'b1;
                    ctrl_d.s1 = sel_b;
                end
            end
            ST_DONE: ctrl_d.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= 8'h00;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ready = ctrl_q.ready;
    assign done  = ctrl_q.done;
    assign l1    = ctrl_q.ld[0];
    assign l2    = ctrl_q.ld[1];
    assign l3    = ctrl_q.ld[2];
    assign l4    = ctrl_q.ld[3];
    assign s1    = ctrl_q.s1;
    assign s2    = ctrl_q.s2;
    assign f     = ctrl_q.f;
    assign w     = ctrl_q.w;
    assign r     = ctrl_q.r;

endmodule : ctrl_unit
`default_nettype wire

// File: tb/tb_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_ctrl_unit
// Brief  : Scoreboard bench for ctrl_unit with an instruction-level reference model
// Rev    : 1.0
// ============================================================================
module tb_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       ready, done, l1, l2, l3, l4, f, w, r;
    logic [2:0] s1, s2;

    int checks   = 0;
    int failures = 0;

    // Control word layout: {ready, done, l1, l2, l3, l4, s1, s2, f, w, r}
    logic [14:0] exp_q[$];
    int          remaining = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    ctrl_unit dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .ready(ready), .done(done),
        .l1(l1), .l2(l2), .l3(l3), .l4(l4),
        .s1(s1), .s2(s2), .f(f), .w(w), .r(r)
    );

    function automatic logic [14:0] word(input logic rdy, input logic dn,
                                         input logic [3:0] loads, input logic [2:0] a,
                                         input logic [2:0] b, input logic fn,
                                         input logic wr, input logic rd);
        return {rdy, dn, loads, a, b, fn, wr, rd};
    endfunction

    function automatic logic [2:0] bus_of(input logic [1:0] src);
        logic [2:0] tbl [4];
        tbl = '{3'd0, 3'd1, 3'd2, 3'd4};
        return tbl[src];
    endfunction

    // {l1,l2,l3,l4}: R1 -> l1 ... AR -> l4
    function automatic logic [3:0] load_of(input logic [1:0] dst);
        return 4'b1000 >> dst;
    endfunction

    // Expected control words for every cycle an instruction occupies after accept.
    task automatic push_instruction(input logic [7:0] ins);
        logic [1:0] op, dst, sa, sb;
        op = ins[7:6]; dst = ins[5:4]; sa = ins[3:2]; sb = ins[1:0];
        if (op == 2'b00 || op == 2'b01) begin
            exp_q.push_back(word(0, 0, load_of(dst), bus_of(sa), bus_of(sb), op[0], 0, 0));
            remaining = 2;
        end else begin
            exp_q.push_back(word(0, 0, 4'b0001, bus_of(sa), 3'd5, 0, 0, 0));
            if (op == 2'b10)
                exp_q.push_back(word(0, 0, load_of(dst), 3'd3, 3'd5, 0, 0, 1));
            else
                exp_q.push_back(word(0, 0, 4'b0000, bus_of(sb), 3'd5, 0, 1, 0));
            remaining = 3;
        end
        exp_q.push_back(word(0, 1, 4'b0000, 3'd5, 3'd5, 0, 0, 0));
    endtask

    task automatic model_edge();
        if (rst) begin
            exp_q.delete();
            remaining = 0;
            mon_en    = 1'b1;
        end else if (remaining == 0 && start) begin
            push_instruction(instr);
        end else if (remaining > 0) begin
            remaining--;
        end
    endtask

    task automatic cycle(input logic st, input logic [7:0] ins, input logic rs);
        start = st;
        instr = ins;
        rst   = rs;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: each cycle the DUT presents a control word; compare it with the
    // scoreboard head, or with the idle word when nothing is in flight.
    always @(negedge clk) begin
        logic [14:0] exp_w, got_w;
        if (mon_en) begin
            got_w = {ready, done, l1, l2, l3, l4, s1, s2, f, w, r};
            if (exp_q.size() > 0) exp_w = exp_q.pop_front();
            else                  exp_w = word(1, 0, 4'b0000, 3'd5, 3'd5, 0, 0, 0);
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL ctrl t=%0t got=%b required=%b (rdy,dn,l1-4,s1,s2,f,w,r)",
                         $time, got_w, exp_w);
            end
            checks++;
            if ($countones({l1, l2, l3, l4}) > 1 || (w && r)) begin
                failures++;
                $display("FAIL exclusive t=%0t loads=%b w=%b r=%b required at most one load, not w&r",
                         $time, {l1, l2, l3, l4}, w, r);
            end
        end
    end

    initial begin
        // Reset held for two cycles, then idle.
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);

        // ADD R2 = R1 + R2, instr input scrambled while busy.
        cycle(1, 8'b00_01_01_10, 0);
        cycle(0, 8'hFF, 0);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);

        // SUB R3 = x - R1.
        cycle(1, 8'b01_10_00_01, 0);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0);

        // LOAD R1 <- mem[R2].
        cycle(1, 8'b10_00_10_00, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0);

        // STORE with start held high: second accept only after DONE.
        for (int i = 0; i < 6; i++) cycle(1, 8'b11_00_01_11, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0);

        // Reset during STORE's MEM cycle, with start also high.
        cycle(1, 8'b11_00_01_11, 0);
        cycle(0, 8'h00, 0);
        cycle(1, 8'b00_00_01_01, 1);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ctrl_unit
`default_nettype wire

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is synchronous and active-high on rst.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk    in   1  rising-edge clock, shared with the datapath
- rst    in   1  synchronous active-high reset
- start  in   1  instruction valid; accepted only while ready=1
- instr  in   8  instruction word, sampled on accept
- ready  out  1  1 while idle and able to accept
- done   out  1  one-cycle pulse at instruction completion
- l1     out  1  R1 load enable
- l2     out  1  R2 load enable
- l3     out  1  R3 load enable
- l4     out  1  AR load enable
- s1     out  3  bus-1 source select
- s2     out  3  bus-2 source select
- f      out  1  ALU function: 0 = add, 1 = subtract
- w      out  1  memory write enable
- r      out  1  memory read enable
REQ-003 Bus select codes SHALL be: 0 = x, 1 = R1, 2 = R2, 3 = mem, 4 = R3, 5 = null (5 to 7 are null).

Function
REQ-004 The instr fields SHALL be: [7:6] opcode (00 ADD, 01 SUB, 10 LOAD, 11 STORE), [5:4] dst (00 R1, 01 R2, 10 R3, 11 AR), [3:2] srcA, [1:0] srcB.
REQ-005 Source codes SHALL map to bus selects as follows: 00 -> 0 (x), 01 -> 1, 10 -> 2, 11 -> 4.
REQ-006 The FSM SHALL have the states IDLE, EXEC, ADDR, MEM and DONE.
REQ-007 IDLE SHALL assert ready=1; all load enables, w, r and f SHALL be 0, and s1 = s2 = 5.
REQ-008 When start=1 in IDLE, the block SHALL latch instr and go to EXEC for ADD/SUB, or to ADDR for LOAD/STORE.
REQ-009 start SHALL be ignored in every state other than IDLE; the latched instr SHALL be unaffected by changes on the instr input.
REQ-010 EXEC SHALL drive s1 = map(srcA), s2 = map(srcB), f = opcode[0], and exactly one load enable per dst (AR selects l4), then go to DONE.
REQ-011 ADDR SHALL drive s1 = map(srcA), s2 = 5, f = 0 and l4 = 1, so that AR takes srcA; it then goes to MEM.
REQ-012 In MEM for a LOAD, the block SHALL drive r = 1, s1 = 3, s2 = 5, f = 0 and the dst load enable; dst = AR is legal and overwrites AR.
REQ-013 In MEM for a STORE, the block SHALL drive w = 1, s1 = map(srcB), s2 = 5, f = 0, with no load enables; dst is ignored.
REQ-014 DONE SHALL assert done = 1 for exactly one cycle with all controls idle, then go to IDLE.
REQ-015 Latency SHALL be: done rises 2 cycles after accept for ADD/SUB, and 3 cycles after accept for LOAD/STORE.
REQ-016 A new instruction SHALL be accepted no earlier than the cycle after DONE.
REQ-017 At most one of l1 to l4 SHALL be high in any cycle, and w and r SHALL never be high together.
REQ-018 All outputs SHALL be registered or decoded from state plus the latched instr only, with no combinational path from start or instr.

Reset
REQ-019 rst = 1 SHALL force IDLE on the next edge, giving ready = 1, done = 0, all loads, w, r and f = 0, s1 = s2 = 5, and a cleared latched instr.
REQ-020 rst SHALL take priority over start; reset during MEM SHALL deassert w and r on the next edge, aborting the access.

Structure
REQ-021 A shared package SHALL hold the opcode constants, the state encoding, the bus-select constants (SEL_X, SEL_R1, SEL_R2, SEL_MEM, SEL_R3, SEL_NULL) and the dst codes.
REQ-022 The source-code to bus-select mapping SHALL be a sub-module, src_sel_dec, instantiated twice (for srcA and srcB).

Verification
REQ-023 Reset: hold rst for 2 cycles, then release -> ready = 1, s1 = s2 = 5, all enables 0.
REQ-024 ADD: instr = 8'b00_01_01_10 (R2 = R1 + R2) -> next cycle s1 = 1, s2 = 2, f = 0, l2 = 1; done 2 cycles after accept.
REQ-025 SUB from x: instr = 8'b01_10_00_01 -> EXEC drives s1 = 0, s2 = 1, f = 1, l3 = 1.
REQ-026 LOAD: instr = 8'b10_00_10_00 -> ADDR: s1 = 2, l4 = 1; MEM: r = 1, s1 = 3, l1 = 1; done at +3 cycles.
REQ-027 STORE with busy-start: instr = 8'b11_00_01_11, with start held high throughout -> MEM: w = 1, s1 = 4; the second accept occurs only after DONE.
REQ-028 Reset in MEM: assert rst during a STORE's MEM cycle -> w = 0 on the next edge, IDLE, and no done pulse.
